fifo_rd_stream: RTL

//   Read-side drain engine for the synchronous FIFO. It pops words from the FIFO read port and

---
 rtl/fifo_rd_stream_if.sv | 25 ++
 rtl/fifo_rd_stream.sv | 100 ++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus outgoing valid/ready stream for the read-side drain engine.
// master = drain engine side, slave = FIFO/consumer environment side.
interface fifo_rd_stream_if #(
  parameter int DATA_SIZE = 8
);
  logic                 fifo_empty;
  logic [DATA_SIZE-1:0] fifo_rd_data;
  logic                 fifo_rd_en;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;
  logic                 flush;
  logic [1:0]           occupancy;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready, flush,
    output fifo_rd_en, m_data, m_valid, m_last, occupancy
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready, flush,
    input  fifo_rd_en, m_data, m_valid, m_last, occupancy
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream through a head+skid buffer.
// Pops are credit-limited so the two buffer entries can never overflow; m_last marks burst ends.
module fifo_rd_stream #(
  parameter int DATA_SIZE = 8,
  parameter int BURST_LEN = 4
) (
  input logic             clk,
  input logic             reset,
  fifo_rd_stream_if.master bus
);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  logic [DATA_SIZE-1:0] head_q, head_d;
  logic [DATA_SIZE-1:0] skid_q, skid_d;
  logic [1:0]           occ_q, occ_d;
  logic [7:0]           beat_q, beat_d;
  logic                 inflight_q;
  logic                 discard_q, discard_d;

  logic                 pop;
  logic                 cap;
  logic                 rd_en;
  logic [2:0]           credit;

  always_comb begin
    pop    = (occ_q != 2'd0) & bus.m_ready;
    credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en  = !reset & !bus.fifo_empty & !bus.flush & (credit < 3'd2);
    // A word returning during a flush cycle is dropped along with the buffer.
    cap    = inflight_q & !discard_q & !bus.flush;

    head_d    = head_q;
    skid_d    = skid_q;
    occ_d     = occ_q;
    beat_d    = beat_q;
    discard_d = 1'b0;

    if (bus.flush) begin
      occ_d     = 2'd0;
      beat_d    = 8'd0;
      discard_d = inflight_q;
    end else begin
      if (pop) begin
        beat_d = (beat_q == LAST_BEAT) ? 8'd0 : beat_q + 8'd1;
      end
      case (occ_q)
        2'd0: begin
          if (cap) begin
            head_d = bus.fifo_rd_data;
            occ_d  = 2'd1;
          end
        end
        2'd1: begin
          if (pop && cap) begin
            head_d = bus.fifo_rd_data;
          end else if (pop) begin
            occ_d = 2'd0;
          end else if (cap) begin
            skid_d = bus.fifo_rd_data;
            occ_d  = 2'd2;
          end
        end
        default: begin
          if (pop) begin
            head_d = skid_q;
            if (cap) begin
              skid_d = bus.fifo_rd_data;
            end else begin
              occ_d = 2'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      skid_q     <= '0;
      occ_q      <= 2'd0;
      beat_q     <= 8'd0;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      occ_q      <= occ_d;
      beat_q     <= beat_d;
      inflight_q <= rd_en;
      discard_q  <= discard_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_data     = head_q;
  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.m_last     = (occ_q != 2'd0) & (beat_q == LAST_BEAT);
  assign bus.occupancy  = occ_q;
endmodule
